// File: rtl/prop_plug_pkg.sv
// Shared types and constants for the Prop Plug host emulator.
package prop_plug_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DTR_LOW,
    BOOT_WAIT,
    STREAM
  } state_t;

  localparam int UART_FRAME_BITS = 10;
  localparam int UART_DATA_BITS  = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/prop_plug_host_if.sv
// Byte-stream and session-control bundle between a boot loader and the Prop Plug host.
interface prop_plug_host_if;
  import prop_plug_pkg::*;

  logic                      start;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic                      dtr_out;
  logic                      txd;
  logic                      streaming;
  logic                      busy;

  modport master (
    output start, tx_data, tx_valid,
    input  tx_ready, dtr_out, txd, streaming, busy
  );

  modport slave (
    input  start, tx_data, tx_valid,
    output tx_ready, dtr_out, txd, streaming, busy
  );

endinterface

// File: rtl/prop_plug_host_uart_tx_8n1.sv
// 8N1 serialiser: start bit, eight data bits LSB first, stop bit, BIT_DIV clocks per bit.
module uart_tx_8n1
  import prop_plug_pkg::*;
#(
  parameter int BIT_DIV = 1389
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic [UART_DATA_BITS-1:0] data,
  input  logic                      valid,
  output logic                      ready,
  output logic                      txd,
  output logic                      busy
);

  localparam int DIV_W  = clog2(BIT_DIV);
  localparam int BITS_W = clog2(UART_FRAME_BITS);

  logic [DIV_W-1:0]           div_cnt;
  logic [BITS_W-1:0]          bit_cnt;
  logic                       active;
  logic [UART_FRAME_BITS-1:0] shreg;
  logic                       bit_end;
  logic                       frame_end;

  assign bit_end   = (div_cnt == DIV_W'(BIT_DIV - 1));
  assign frame_end = active && bit_end && (bit_cnt == BITS_W'(UART_FRAME_BITS - 1));

  always_ff @(posedge clk) begin
    if (res) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (!active) begin
      if (valid) begin
        active  <= 1'b1;
        div_cnt <= '0;
        bit_cnt <= '0;
      end
    end else if (bit_end) begin
      div_cnt <= '0;
      if (frame_end) begin
        active  <= 1'b0;
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Shift register carries the whole frame; bit 0 is always the bit on the line.
  always_ff @(posedge clk) begin
    if (!active && valid) begin
      shreg <= {1'b1, data, 1'b0};
    end else if (active && bit_end) begin
      shreg <= {1'b1, shreg[UART_FRAME_BITS-1:1]};
    end
  end

  // ready means "idle on the next cycle", so the last stop-bit cycle counts.
  assign ready = !active || frame_end;
  assign busy  = active;
  assign txd   = active ? shreg[0] : 1'b1;

endmodule

// File: rtl/prop_plug_host.sv
// Prop Plug host: drives DTR to reset the core, waits for boot, then streams bytes as 8N1.
module prop_plug_host
  import prop_plug_pkg::*;
#(
  parameter int BIT_DIV          = 1389,
  parameter int DTR_LOW_CYCLES   = 16000,
  parameter int BOOT_WAIT_CYCLES = 16000000
) (
  input  logic             clk,
  input  logic             res,
  prop_plug_host_if.slave  bus
);

  localparam int WAIT_MAX = (DTR_LOW_CYCLES > BOOT_WAIT_CYCLES) ? DTR_LOW_CYCLES : BOOT_WAIT_CYCLES;
  localparam int WAIT_W   = (clog2(WAIT_MAX) > 0) ? clog2(WAIT_MAX) : 1;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] cnt, cnt_nxt;
  logic              pending, pending_nxt;
  logic              uart_ready;
  logic              uart_busy;
  logic              uart_valid;
  logic              tx_ready;

  always_ff @(posedge clk) begin
    if (res) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = DTR_LOW;
          cnt_nxt   = '0;
        end
      end
      DTR_LOW: begin
        if (bus.start) begin
          cnt_nxt = '0;
        end else if (cnt == WAIT_W'(DTR_LOW_CYCLES - 1)) begin
          state_nxt = BOOT_WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      BOOT_WAIT: begin
        if (bus.start) begin
          state_nxt = DTR_LOW;
          cnt_nxt   = '0;
        end else if (cnt == WAIT_W'(BOOT_WAIT_CYCLES - 1)) begin
          state_nxt = STREAM;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STREAM: begin
        // A restart waits for the frame on the wire to finish its stop bit.
        if ((bus.start || pending) && uart_ready) begin
          state_nxt   = DTR_LOW;
          cnt_nxt     = '0;
          pending_nxt = 1'b0;
        end else if (bus.start) begin
          pending_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign tx_ready   = (state == STREAM) && !bus.start && !pending && !uart_busy;
  assign uart_valid = bus.tx_valid && tx_ready;

  uart_tx_8n1 #(
    .BIT_DIV (BIT_DIV)
  ) u_uart (
    .clk   (clk),
    .res   (res),
    .data  (bus.tx_data),
    .valid (uart_valid),
    .ready (uart_ready),
    .txd   (bus.txd),
    .busy  (uart_busy)
  );

  assign bus.tx_ready  = tx_ready;
  assign bus.dtr_out   = (state == BOOT_WAIT) || (state == STREAM);
  assign bus.streaming = (state == STREAM);
  assign bus.busy      = uart_busy;

endmodule

// File: tb/tb_prop_plug_host.sv
// Bench for prop_plug_host: timeline-based reference model plus directed and random stimulus.
module tb_prop_plug_host;

  localparam int BD = 4;
  localparam int DL = 8;
  localparam int BW = 16;

  logic clk = 1'b0;
  logic res;
  int   n_pass  = 0;
  int   n_total = 0;
  int   tb_cyc  = 0;
  bit   chk_en  = 1'b0;

  prop_plug_host_if bus ();

  prop_plug_host #(
    .BIT_DIV          (BD),
    .DTR_LOW_CYCLES   (DL),
    .BOOT_WAIT_CYCLES (BW)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: session start time, frame start time, pending restart flag.
  int   m_cyc  = 0;
  int   m_t0   = -1;
  int   m_f0   = -1;
  bit   m_pend = 1'b0;
  logic [7:0] m_byte = 8'h00;

  function automatic bit m_stream();
    return (m_t0 >= 0) && ((m_cyc - m_t0) >= DL + BW);
  endfunction

  function automatic bit m_dtr();
    return (m_t0 >= 0) && ((m_cyc - m_t0) >= DL);
  endfunction

  function automatic bit m_fbusy();
    return (m_f0 >= 0) && ((m_cyc - m_f0) < 10 * BD);
  endfunction

  function automatic bit m_txd();
    int idx;
    if (!m_fbusy()) return 1'b1;
    idx = (m_cyc - m_f0) / BD;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_byte[idx-1];
  endfunction

  function automatic bit m_ready();
    return m_stream() && !m_fbusy() && !m_pend && !bus.start;
  endfunction

  always @(posedge clk) begin
    m_cyc <= m_cyc + 1;
    if (res) begin
      m_t0   <= -1;
      m_f0   <= -1;
      m_pend <= 1'b0;
    end else begin
      if (bus.tx_valid && m_ready()) begin
        m_f0   <= m_cyc + 1;
        m_byte <= bus.tx_data;
      end
      if (!m_stream()) begin
        if (bus.start) m_t0 <= m_cyc + 1;
      end else if ((bus.start || m_pend) && (!m_fbusy() || (m_cyc - m_f0) == 10 * BD - 1)) begin
        m_t0   <= m_cyc + 1;
        m_pend <= 1'b0;
      end else if (bus.start) begin
        m_pend <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, tb_cyc);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_dtr_out",   bus.dtr_out,   m_dtr());
      check("m_txd",       bus.txd,       m_txd());
      check("m_tx_ready",  bus.tx_ready,  m_ready());
      check("m_streaming", bus.streaming, m_stream());
      check("m_busy",      bus.busy,      m_fbusy());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tb_cyc++;
  endtask

  int a5_bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int s1, s2;

  initial begin
    res = 1'b1;
    bus.start = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    tick();
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_dtr", bus.dtr_out, 0);
    check("rst_txd", bus.txd, 1);
    check("rst_ready", bus.tx_ready, 0);
    check("rst_streaming", bus.streaming, 0);
    check("rst_busy", bus.busy, 0);
    tick();
    res = 1'b0;

    // Session from IDLE: start in cycle 0.
    bus.start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      bus.start = 1'b0;
      @(negedge clk);
      if (k == 8) check("dtr_low_last", bus.dtr_out, 0);
      if (k == 9) check("dtr_rise", bus.dtr_out, 1);
      if (k == 24) check("stream_early", bus.streaming, 0);
      if (k == 25) begin
        check("stream_on", bus.streaming, 1);
        check("ready_on", bus.tx_ready, 1);
      end
    end

    // 0xA5 frame.
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'hA5;
    for (int i = 0; i < 40; i++) begin
      tick();
      bus.tx_valid = 1'b0;
      @(negedge clk);
      check("a5_txd", bus.txd, a5_bits[i/BD]);
      check("a5_busy", bus.busy, 1);
    end
    tick();
    @(negedge clk);
    check("a5_busy_end", bus.busy, 0);
    check("a5_ready_back", bus.tx_ready, 1);

    // 0x00 then 0xFF back to back.
    tick();
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h00;
    tick();
    s1 = tb_cyc;
    bus.tx_data = 8'hFF;
    s2 = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.tx_ready) begin
        tick();
        s2 = tb_cyc;
        break;
      end
      tick();
    end
    bus.tx_valid = 1'b0;
    check("b2b_spacing", s2 - s1, 41);
    repeat (41) tick();

    // Reset during frame cycle 12.
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'($urandom);
    tick();
    bus.tx_valid = 1'b0;
    repeat (11) tick();
    res = 1'b1;
    tick();
    res = 1'b0;
    @(negedge clk);
    check("midres_txd", bus.txd, 1);
    check("midres_dtr", bus.dtr_out, 0);
    check("midres_ready", bus.tx_ready, 0);
    check("midres_busy", bus.busy, 0);
    check("midres_streaming", bus.streaming, 0);

    // tx_valid held through DTR_LOW and BOOT_WAIT.
    tick();
    bus.start = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h3C;
    for (int k = 1; k <= 25; k++) begin
      tick();
      bus.start = 1'b0;
      @(negedge clk);
      if (k < 25) begin
        check("wait_ready", bus.tx_ready, 0);
        check("wait_txd", bus.txd, 1);
      end else begin
        check("first_stream_ready", bus.tx_ready, 1);
      end
    end
    tick();
    bus.tx_valid = 1'b0;
    @(negedge clk);
    check("early_byte_busy", bus.busy, 1);
    check("early_byte_start", bus.txd, 0);

    // start at frame cycle 5: frame finishes, then the session reruns.
    repeat (4) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int f = 6; f <= 65; f++) begin
      @(negedge clk);
      if (f <= 40) begin
        check("restart_ready", bus.tx_ready, 0);
        check("restart_busy", bus.busy, 1);
      end
      if (f == 40) check("restart_dtr_hold", bus.dtr_out, 1);
      if (f == 41) begin
        check("restart_dtr_fall", bus.dtr_out, 0);
        check("restart_busy_end", bus.busy, 0);
      end
      if (f == 64) check("restart_stream_early", bus.streaming, 0);
      if (f == 65) check("restart_stream_on", bus.streaming, 1);
      tick();
    end

    // res and start together: res wins, stays IDLE.
    res = 1'b1;
    bus.start = 1'b1;
    tick();
    res = 1'b0;
    bus.start = 1'b0;
    repeat (9) tick();
    @(negedge clk);
    check("res_wins_dtr", bus.dtr_out, 0);
    tick();

    // Random traffic, restarts and resets.
    for (int n = 0; n < 1500; n++) begin
      bus.tx_valid = ($urandom % 4) != 0;
      bus.tx_data = 8'($urandom);
      bus.start = ($urandom % 200) == 0;
      res = ($urandom % 400) == 0;
      tick();
    end
    res = 1'b0;
    bus.start = 1'b0;
    bus.tx_valid = 1'b0;
    repeat (5) tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
